sobel_window_gen: RTL and testbench
===================================

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 The module SHALL have parameter WIDTH, default 240, image columns (at least 3).
REQ-002 The module SHALL have parameter HEIGHT, default 240, image rows (at least 3).
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, the reset, which is synchronous and active-high.
REQ-005 The module SHALL have port in_valid, input, 1 bit: in_pix holds a valid pixel.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block can accept a pixel.
REQ-007 The module SHALL have port in_pix, input, 8 bits, the grayscale pixel, delivered in raster order.
REQ-008 The module SHALL have port out_valid, output, 1 bit: a 3x3 window is presented.
REQ-009 The module SHALL have port out_ready, input, 1 bit: the downstream Sobel core accepts the window.
REQ-010 The module SHALL have port out_win, output, 72 bits, holding nine pixels.
REQ-011 The module SHALL have port out_x, output, 16 bits, the column of the window centre.
REQ-012 The module SHALL have port out_y, output, 16 bits, the row of the window centre.
REQ-013 The module SHALL have port frame_done, output, 1 bit, a one-cycle pulse after the last window of a frame is accepted.

Function
REQ-014 A pixel SHALL be accepted on a cycle with in_valid && in_ready.
- A window is accepted on a cycle with out_valid && out_ready.
REQ-015 in_ready SHALL equal !out_valid || out_ready, as a combinational path; this gives full throughput of 1 pixel/cycle.
REQ-016 Column counter x (0..WIDTH-1) and row counter y (0..HEIGHT-1) SHALL advance on each accepted pixel.
- x wraps to 0 and increments y.
- After (WIDTH-1, HEIGHT-1), both wrap to 0 and the next frame begins.
REQ-017 Two line buffers of WIDTH x 8 bits SHALL hold rows y-1 and y-2.
- On accept at column x: read both entries at x, shift row y-1 into row y-2 at x, and write in_pix into row y-1 at x, all in the same cycle.
REQ-018 A 3x3 column shift register SHALL shift in {row y-2, row y-1, in_pix} at column x on every accept.
REQ-019 A window SHALL be produced only for accepts with x>=2 and y>=2 (valid convolution only, no padding).
- Each frame yields (WIDTH-2)*(HEIGHT-2) windows.
REQ-020 Latency: out_valid SHALL rise in the cycle after the producing accept.
- out_x = x-1.
- out_y = y-1.
REQ-021 Window packing SHALL be out_win[8*k +: 8], with k = 3*r + c.
- r=0 is the top row (y-2); c=0 is the left column (x-2).
- k=4 is the centre.
REQ-022 While out_valid && !out_ready, out_win, out_x and out_y SHALL hold stable and no pixel SHALL be accepted.
REQ-023 Accepts with x<2 or y<2 SHALL update the buffers only and SHALL NOT assert out_valid.
REQ-024 State machine: the module SHALL have states FILL (y<2), STREAM (y>=2) and LAST (last window pending).
- FILL to STREAM: on the accept with x=WIDTH-1, y=1.
- STREAM to LAST: on the accept with x=WIDTH-1, y=HEIGHT-1.
- LAST to FILL: when that window is accepted; frame_done pulses in the following cycle.
REQ-025 A simultaneous out accept and in accept in the same cycle SHALL load the new window without a bubble.

Reset
REQ-026 When rst is high at a clock edge, the following SHALL be cleared:
- out_valid=0, frame_done=0, out_win=0, out_x=0, out_y=0.
- x=0, y=0, state FILL.
- in_ready is then 1.
REQ-027 Line buffer contents SHALL NOT be cleared; FILL gating guarantees stale data is never emitted.
REQ-028 Reset mid-frame SHALL discard the partial frame; the next accepted pixel is (0,0).

Configuration
REQ-029 The macro SOBEL_WIN_PERF_EN SHALL control an extra output port frame_cycles (32 bits).
- With the macro defined, frame_cycles is a cycle count from the first accept of a frame to the frame_done pulse inclusive.
- frame_cycles updates when frame_done pulses, holds until the next frame completes, and resets to 0.
- Without the macro, neither the port nor the counter exists, and all other behaviour is identical.

Structure
REQ-030 Package sobel_pkg SHALL hold the following:
- PIX_W=8.
- the typedef pix_t.
- the typedef win_t as an array of 9 pix_t.
- the state enum win_state_t.
- defaults DEF_WIDTH=240 and DEF_HEIGHT=240.
REQ-031 The line buffer SHALL be sub-module sobel_line_buf: parameterised depth, synchronous write, read of the same address in the same cycle (read-before-write).

Verification (WIDTH=4, HEIGHT=4, in_pix=16*y+x, unless stated otherwise)
REQ-032 Stream 16 pixels with out_ready=1 -> exactly 4 windows, at (1,1), (2,1), (1,2), (2,2).
- First window: out_win k0..k8 = 00,01,02,10,11,12,20,21,22 (hex).
- frame_done pulses once.
REQ-033 Hold out_ready=0 at the first window for 5 cycles -> in_ready=0, the window is held stable, and no pixel is lost; the remaining windows are correct.
REQ-034 Two back-to-back frames -> frame 2 windows are identical to frame 1 windows, with no stale row-mixing.
REQ-035 Assert rst after 7 pixels, then stream a full frame -> outputs match REQ-032 exactly.
REQ-036 Random in_valid/out_ready gaps, 240x240 frame -> 238*238 windows matching a reference model; under SOBEL_WIN_PERF_EN, frame_cycles equals the measured cycle count.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel 3x3 window generator.
package sobel_pkg;

    localparam int PIX_W      = 8;
    localparam int DEF_WIDTH  = 240;
    localparam int DEF_HEIGHT = 240;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [8:0]       win_t;

    typedef enum logic [1:0] {
        FILL,
        STREAM,
        LAST
    } win_state_t;

    // Window slot for row r (0 = top) and column c (0 = left); slot 4 is the centre.
    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One image row of pixel storage: combinational read of the addressed entry,
// write to the same entry at the clock edge, so a same-cycle read returns the old pixel.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = DEF_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [PIX_W-1:0] i_wdata,
    output logic [PIX_W-1:0] o_rdata
);

    pix_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-order pixel stream to 3x3 window stream (valid convolution, no padding).
// Define SOBEL_WIN_PERF_EN to add the frame_cycles performance counter output.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_pix,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [71:0] out_win,
    output logic [15:0] out_x,
    output logic [15:0] out_y,
    output logic        frame_done
`ifdef SOBEL_WIN_PERF_EN
    ,
    output logic [31:0] frame_cycles
`endif
);

    localparam int LB_AW = $clog2(WIDTH);

    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_out_x;
    logic [15:0] r_out_y;
    logic        r_out_valid;
    logic        r_frame_done;
    win_t        r_win;
    win_state_t  r_state;
    win_state_t  w_state_nxt;

    pix_t [2:0]  r_col0;
    pix_t [2:0]  r_col1;
    pix_t [2:0]  w_col_new;
    win_t        w_win_nxt;

    logic             w_in_acc;
    logic             w_out_acc;
    logic             w_x_last;
    logic             w_y_last;
    logic             w_prod;
    logic             w_frame_end;
    logic [LB_AW-1:0] w_addr;
    pix_t             w_row1;
    pix_t             w_row2;

    assign in_ready    = !r_out_valid || out_ready;
    assign w_in_acc    = in_valid && in_ready;
    assign w_out_acc   = r_out_valid && out_ready;
    assign w_x_last    = (r_x == 16'(WIDTH - 1));
    assign w_y_last    = (r_y == 16'(HEIGHT - 1));
    assign w_prod      = w_in_acc && (r_x >= 16'd2) && (r_y >= 16'd2);
    assign w_frame_end = (r_state == LAST) && w_out_acc;
    assign w_addr      = r_x[LB_AW-1:0];

    // Row y-1 takes the incoming pixel; row y-2 takes what row y-1 held at this column.
    sobel_line_buf #(.DEPTH(WIDTH)) u_lb_row1 (
        .i_clk   (clk),
        .i_we    (w_in_acc),
        .i_addr  (w_addr),
        .i_wdata (in_pix),
        .o_rdata (w_row1)
    );

    sobel_line_buf #(.DEPTH(WIDTH)) u_lb_row2 (
        .i_clk   (clk),
        .i_we    (w_in_acc),
        .i_addr  (w_addr),
        .i_wdata (w_row1),
        .o_rdata (w_row2)
    );

    assign w_col_new = {in_pix, w_row1, w_row2};

    always_comb begin
        w_win_nxt = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            w_win_nxt[win_idx(r, 0)] = r_col0[r];
            w_win_nxt[win_idx(r, 1)] = r_col1[r];
            w_win_nxt[win_idx(r, 2)] = w_col_new[r];
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_acc) begin
            r_col0 <= r_col1;
            r_col1 <= w_col_new;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_in_acc && w_x_last && (r_y == 16'd1)) w_state_nxt = STREAM;
            STREAM:  if (w_in_acc && w_x_last && w_y_last)       w_state_nxt = LAST;
            LAST:    if (w_out_acc)                              w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FILL;
            r_x          <= '0;
            r_y          <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_win        <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_frame_end;
            if (w_in_acc) begin
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + 16'd1;
                end else begin
                    r_x <= r_x + 16'd1;
                end
            end
            if (w_prod) begin
                r_out_valid <= 1'b1;
                r_win       <= w_win_nxt;
                r_out_x     <= r_x - 16'd1;
                r_out_y     <= r_y - 16'd1;
            end else if (w_out_acc) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_win    = r_win;
    assign out_x      = r_out_x;
    assign out_y      = r_out_y;
    assign frame_done = r_frame_done;

`ifdef SOBEL_WIN_PERF_EN
    logic [31:0] r_cyc_cnt;
    logic        r_cyc_run;
    logic [31:0] r_frame_cycles;

    // r_cyc_cnt holds cycles elapsed since the first accept; +2 adds the current and pulse cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt      <= '0;
            r_cyc_run      <= 1'b0;
            r_frame_cycles <= '0;
        end else begin
            if (r_cyc_run) begin
                r_cyc_cnt <= r_cyc_cnt + 32'd1;
            end
            if (w_frame_end) begin
                r_frame_cycles <= r_cyc_cnt + 32'd2;
                r_cyc_run      <= 1'b0;
            end
            if (w_in_acc && (r_x == 16'd0) && (r_y == 16'd0)) begin
                r_cyc_cnt <= 32'd1;
                r_cyc_run <= 1'b1;
            end
        end
    end

    assign frame_cycles = r_frame_cycles;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 4x4 frame: constant window table plus an image-based scoreboard.
module tb_sobel_window_gen;

    localparam int TW = 4;
    localparam int TH = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic [7:0]  in_pix    = '0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [71:0] out_win;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic        frame_done;
`ifdef SOBEL_WIN_PERF_EN
    logic [31:0] frame_cycles;
`endif

    always #5 clk = ~clk;

    sobel_window_gen #(.WIDTH(TW), .HEIGHT(TH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pix     (in_pix),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_win    (out_win),
        .out_x      (out_x),
        .out_y      (out_y),
        .frame_done (frame_done)
`ifdef SOBEL_WIN_PERF_EN
        ,
        .frame_cycles (frame_cycles)
`endif
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [71:0] win;
    } win_rec_t;

    win_rec_t   tbl [4];
    win_rec_t   sb_q [$];
    win_rec_t   cap_q [$];
    win_rec_t   m_rec;
    logic [7:0] img [TH][TW];

    int   checks     = 0;
    int   failures   = 0;
    int   bx         = 0;
    int   by         = 0;
    int   win_cnt    = 0;
    int   done_cnt   = 0;
    int   cyc        = 0;
    int   start_cyc  = 0;
    int   done_start = 0;
    logic exp_done   = 1'b0;
    logic stop_rnd   = 1'b0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
    endtask

    // Scoreboard: expected windows come from the bench's own copy of the accepted image.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb_q.delete();
            bx       = 0;
            by       = 0;
            exp_done = 1'b0;
        end else begin
            check("out_valid", 72'(out_valid), 72'(sb_q.size() != 0));
            check("in_ready", 72'(in_ready), 72'((sb_q.size() == 0) || out_ready));
            check("frame_done", 72'(frame_done), 72'(exp_done));
`ifdef SOBEL_WIN_PERF_EN
            if (frame_done)
                check("frame_cycles", 72'(frame_cycles), 72'(cyc - done_start + 1));
`endif
            if (frame_done) done_cnt++;
            exp_done = 1'b0;
            if (out_valid && sb_q.size() != 0) begin
                check("out_win", out_win, sb_q[0].win);
                check("out_x", 72'(out_x), 72'(sb_q[0].x));
                check("out_y", 72'(out_y), 72'(sb_q[0].y));
                if (out_ready) begin
                    m_rec = sb_q.pop_front();
                    cap_q.push_back(m_rec);
                    win_cnt++;
                    if (m_rec.x == 16'(TW - 2) && m_rec.y == 16'(TH - 2)) begin
                        exp_done   = 1'b1;
                        done_start = start_cyc;
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (bx == 0 && by == 0) start_cyc = cyc;
                img[by][bx] = in_pix;
                if (bx >= 2 && by >= 2) begin
                    m_rec.x   = 16'(bx - 1);
                    m_rec.y   = 16'(by - 1);
                    m_rec.win = '0;
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            m_rec.win[8*(3*r+c) +: 8] = img[by-2+r][bx-2+c];
                    sb_q.push_back(m_rec);
                end
                if (bx == TW - 1) begin
                    bx = 0;
                    by = (by == TH - 1) ? 0 : by + 1;
                end else begin
                    bx++;
                end
            end
        end
    end

    task automatic send_pix(input logic [7:0] p, input int gap);
        bit ok;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_pix   = p;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("pixel_accept");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic stream_frame();
        for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x++)
                send_pix(8'(16 * y + x), 0);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("drain");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 72'(out_valid), 72'(0));
        check("rst_frame_done", 72'(frame_done), 72'(0));
        check("rst_out_win", out_win, 72'(0));
        check("rst_out_x", 72'(out_x), 72'(0));
        check("rst_out_y", 72'(out_y), 72'(0));
        check("rst_in_ready", 72'(in_ready), 72'(1));
`ifdef SOBEL_WIN_PERF_EN
        check("rst_frame_cycles", 72'(frame_cycles), 72'(0));
`endif
        out_ready = 1'b1;
    endtask

    task automatic start_test();
        cap_q.delete();
        win_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic compare_table(input int nframes, input string tag);
        check({tag, "_win_count"}, 72'(cap_q.size()), 72'(4 * nframes));
        check({tag, "_done_count"}, 72'(done_cnt), 72'(nframes));
        for (int i = 0; i < 4 * nframes; i++) begin
            if (i < cap_q.size()) begin
                check({tag, "_tbl_x"}, 72'(cap_q[i].x), 72'(tbl[i % 4].x));
                check({tag, "_tbl_y"}, 72'(cap_q[i].y), 72'(tbl[i % 4].y));
                check({tag, "_tbl_win"}, cap_q[i].win, tbl[i % 4].win);
            end
        end
    endtask

    initial begin
        // Expected windows for in_pix = 16*y + x; slot k0 sits in the low byte.
        tbl[0] = '{x: 16'd1, y: 16'd1, win: 72'h22_21_20_12_11_10_02_01_00};
        tbl[1] = '{x: 16'd2, y: 16'd1, win: 72'h23_22_21_13_12_11_03_02_01};
        tbl[2] = '{x: 16'd1, y: 16'd2, win: 72'h32_31_30_22_21_20_12_11_10};
        tbl[3] = '{x: 16'd2, y: 16'd2, win: 72'h33_32_31_23_22_21_13_12_11};

        apply_reset();

        start_test();
        stream_frame();
        drain();
        compare_table(1, "basic");

        start_test();
        out_ready = 1'b0;
        fork
            stream_frame();
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) bound_fail("stall_wait");
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        compare_table(1, "stall");

        start_test();
        stream_frame();
        stream_frame();
        drain();
        compare_table(2, "b2b");

        for (int p = 0; p < 7; p++)
            send_pix(8'(16 * (p / TW) + (p % TW)), 0);
        apply_reset();
        start_test();
        stream_frame();
        drain();
        compare_table(1, "midrst");

        start_test();
        stop_rnd = 1'b0;
        fork
            begin
                for (int f = 0; f < 30; f++)
                    for (int i = 0; i < TW * TH; i++)
                        send_pix(8'($urandom_range(0, 255)), $urandom_range(0, 2));
                stop_rnd = 1'b1;
            end
            begin
                while (!stop_rnd) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("rand_win_count", 72'(win_cnt), 72'(30 * (TW - 2) * (TH - 2)));
        check("rand_done_count", 72'(done_cnt), 72'(30));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
